cpu_state_seq: RTL and testbench
================================

# cpu_state_seq

Multicycle state sequencer for the MIPS core: owns the `state_t` register that drives the control decoder. It advances FETCH → EXEC1 → EXEC2 → FETCH and holds the current state while the memory bus asserts waitrequest or the multiply/divide unit is busy. It detects the halt condition (fetch from address 0) and exposes `active_o`, a PC/IR write qualifier, and retire/stall counters for the testbench.

## Interface
- `CNT_W`, default 32: width of the retire and stall counters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_i`  in  32  current PC value from the PC register.
- `ram_read_en_i`  in  1  read request from the control decoder in the current state.
- `ram_write_en_i`  in  1  write request from the control decoder in the current state.
- `waitrequest_i`  in  1  memory bus stall; the access in the current cycle has not completed.
- `muldiv_busy_i`  in  1  multiply/divide unit still computing HI/LO.
- `is_muldiv_read_i`  in  1  current instruction is MFHI or MFLO.
- `state_o`  out  `state_t`  current state: FETCH, EXEC1, EXEC2 or HALTED.
- `advance_o`  out  1  state leaves its current value at the next edge.
- `active_o`  out  1  CPU is running, i.e. not HALTED.
- `retire_count_o`  out  CNT_W  instructions completed.
- `stall_count_o`  out  CNT_W  cycles spent held in a non-HALTED state.

## Operation
- Reset values, applied at the edge where `reset`=1: `state_o`=FETCH, `active_o`=1, both counters 0. `advance_o` is combinational.
- `mem_stall` = (`ram_read_en_i` | `ram_write_en_i`) & `waitrequest_i`.
- `md_stall` = (`state_o`==EXEC2) & `is_muldiv_read_i` & `muldiv_busy_i`.
- `hold` = `mem_stall` | `md_stall`.
- Halt check in FETCH: if `pc_i`==0, the next state is HALTED regardless of `hold`. No fetch is counted and no retire occurs.
- Transitions when not `hold`:
  - FETCH → EXEC1
  - EXEC1 → EXEC2
  - EXEC2 → FETCH
- When `hold`, the state is unchanged.
- HALTED → HALTED. Only `reset` exits HALTED.
- `advance_o` = !`hold` & (`state_o`!=HALTED). It is 1 in FETCH with `pc_i`==0.
- The top level ANDs the decoder's `pc_write_en`, `ir_write_en` and `regfile_write_en` with `advance_o`. A held EXEC2 therefore never double-writes the PC or register file.
- `active_o` = (`state_o`!=HALTED), driven from a register.
- `retire_count_o` increments by 1 on each edge where EXEC2 → FETCH. It wraps modulo 2^CNT_W.
- `stall_count_o` increments on each edge where `hold` & `state_o`!=HALTED. It wraps modulo 2^CNT_W.
- Simultaneous `mem_stall` and `md_stall` in one cycle add 1 stall, not 2.
- If `state_o` is an illegal encoding, the next state is FETCH.

## Timing
- Unstalled instruction: exactly 3 cycles, FETCH / EXEC1 / EXEC2.
- Each cycle of `hold` adds exactly 1 cycle in the current state.
- `waitrequest_i` is sampled in the same cycle as the request, with no registered bus handshake. The state advances at the first edge where `waitrequest_i`=0.
- Halt: FETCH with `pc_i`==0 at edge N gives `state_o`=HALTED and `active_o`=0 from edge N onward.
- `reset` mid-instruction, in any state including a held one: FETCH at the next edge, with counters cleared. An in-flight access is abandoned. `advance_o` stays 0 during the reset cycle only if a `hold` condition is present.
- `reset` has priority over halt detection and over `hold`.
- No combinational path from `pc_i` to `advance_o` other than the FETCH halt check.

## Test plan
- **Reset, then no stalls, `pc_i`=0xBFC00000:** `state_o` runs FETCH, EXEC1, EXEC2, FETCH…; after 30 cycles `retire_count_o`=10, `stall_count_o`=0, `active_o`=1.
- **Memory stall in FETCH:** `waitrequest_i`=1 for 3 cycles while `ram_read_en_i`=1 → FETCH held 4 cycles total, `advance_o`=0 for the first 3, `stall_count_o`=3, then EXEC1.
- **MFLO with `muldiv_busy_i`=1 for 5 cycles in EXEC2:** EXEC2 held 6 cycles, `retire_count_o` increments once only; the same test with `is_muldiv_read_i`=0 shows no hold.
- **Halt:** after 2 instructions, `pc_i`=0 in FETCH → HALTED next edge, `active_o`=0, `retire_count_o`=2, and it stays halted for 20 cycles with counters frozen even if `waitrequest_i` toggles.
- **Reset during a held EXEC1 (`waitrequest_i`=1):** next state FETCH, counters 0, `active_o`=1; a reset pulse from HALTED restores FETCH.
- **Counter wrap with `CNT_W`=4:** after 16 unstalled instructions `retire_count_o` = 0.

Source files
------------

// File: rtl/cpu_state_seq.sv
// rtl/cpu_state_seq.sv - multicycle FETCH/EXEC1/EXEC2 sequencer with halt detection and counters
package cpu_state_pkg;
  // One-hot running states; all-zero is HALTED, any other code is illegal and recovers to FETCH.
  typedef enum logic [2:0] {
    HALTED = 3'b000,
    FETCH  = 3'b001,
    EXEC1  = 3'b010,
    EXEC2  = 3'b100
  } state_t;
endpackage

module cpu_state_seq
  import cpu_state_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_i,
  input  logic             ram_read_en_i,
  input  logic             ram_write_en_i,
  input  logic             waitrequest_i,
  input  logic             muldiv_busy_i,
  input  logic             is_muldiv_read_i,
  output state_t           state_o,
  output logic             advance_o,
  output logic             active_o,
  output logic [CNT_W-1:0] retire_count_o,
  output logic [CNT_W-1:0] stall_count_o
);

  state_t           state_q, state_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic mem_stall;
  logic md_stall;
  logic hold;
  logic halt_fetch;
  logic running;

  // The bus handshake is combinational: waitrequest qualifies the access of this same cycle.
  assign mem_stall  = (ram_read_en_i | ram_write_en_i) & waitrequest_i;
  assign md_stall   = (state_q == EXEC2) & is_muldiv_read_i & muldiv_busy_i;
  assign hold       = mem_stall | md_stall;
  assign halt_fetch = (state_q == FETCH) & (pc_i == 32'd0);
  assign running    = (state_q != HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      active_q <= 1'b1;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (halt_fetch) begin
          state_d = HALTED;
        end else if (!hold) begin
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        if (!hold) begin
          state_d = EXEC2;
        end
      end
      EXEC2: begin
        if (!hold) begin
          state_d = FETCH;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    active_d = (state_d != HALTED);
    retire_d = retire_q;
    stall_d  = stall_q;
    if ((state_q == EXEC2) && !hold) begin
      retire_d = retire_q + CNT_W'(1);
    end
    if (hold && running) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // A halting fetch always leaves FETCH, even if the bus is stalling that cycle.
  always_comb begin
    advance_o      = running & (!hold | halt_fetch);
    state_o        = state_q;
    active_o       = active_q;
    retire_count_o = retire_q;
    stall_count_o  = stall_q;
  end

endmodule

// File: tb/tb_cpu_state_seq.sv
// tb/tb_cpu_state_seq.sv - scoreboard bench for cpu_state_seq
module tb_cpu_state_seq;
  import cpu_state_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic        adv;
    logic        act;
    logic [31:0] ret;
    logic [31:0] stl;
    logic [15:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        rd, wr, wt, busy, mdr;

  state_t      st32, st4;
  logic        adv32, adv4, act32, act4;
  logic [31:0] ret32, stl32;
  logic [3:0]  ret4, stl4;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc  = 0;

  always #5 clk = ~clk;

  cpu_state_seq #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .pc_i(pc),
    .ram_read_en_i(rd), .ram_write_en_i(wr), .waitrequest_i(wt),
    .muldiv_busy_i(busy), .is_muldiv_read_i(mdr),
    .state_o(st32), .advance_o(adv32), .active_o(act32),
    .retire_count_o(ret32), .stall_count_o(stl32)
  );

  cpu_state_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .pc_i(pc),
    .ram_read_en_i(rd), .ram_write_en_i(wr), .waitrequest_i(wt),
    .muldiv_busy_i(busy), .is_muldiv_read_i(mdr),
    .state_o(st4), .advance_o(adv4), .active_o(act4),
    .retire_count_o(ret4), .stall_count_o(stl4)
  );

  function automatic state_t st_of(input int k);
    case (k)
      0:       return FETCH;
      1:       return EXEC1;
      default: return EXEC2;
    endcase
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected before the next edge.
  task automatic cyc(input logic i_rd, input logic i_wr, input logic i_wt,
                     input logic i_busy, input logic i_mdr, input logic [31:0] i_pc,
                     input state_t est, input logic eadv, input logic eact,
                     input int eret, input int estl);
    exp_t e;
    rd = i_rd; wr = i_wr; wt = i_wt; busy = i_busy; mdr = i_mdr; pc = i_pc;
    e.st  = est;
    e.adv = eadv;
    e.act = eact;
    e.ret = eret;
    e.stl = estl;
    e.cyc = 16'(ncyc);
    exp_q.push_back(e);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state",     int'(e.cyc), 32'(st32),  32'(e.st));
      chk("advance",   int'(e.cyc), 32'(adv32), 32'(e.adv));
      chk("active",    int'(e.cyc), 32'(act32), 32'(e.act));
      chk("retire",    int'(e.cyc), ret32,      e.ret);
      chk("stall",     int'(e.cyc), stl32,      e.stl);
      chk("retire_w4", int'(e.cyc), 32'(ret4),  32'(e.ret[3:0]));
      chk("stall_w4",  int'(e.cyc), 32'(stl4),  32'(e.stl[3:0]));
      chk("state_w4",  int'(e.cyc), 32'(st4),   32'(e.st));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] PC = 32'hBFC0_0000;

  initial begin
    reset = 1'b1; pc = PC; rd = 0; wr = 0; wt = 0; busy = 0; mdr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Unstalled run: 16 instructions, 4-bit counters wrap at the end.
    for (int i = 0; i < 48; i++) begin
      cyc((i % 3) == 0, 0, 0, 0, 0, PC, st_of(i % 3), 1, 1, i / 3, 0);
    end

    // FETCH held by waitrequest for 3 cycles.
    cyc(1, 0, 1, 0, 0, PC, FETCH, 0, 1, 16, 0);
    cyc(1, 0, 1, 0, 0, PC, FETCH, 0, 1, 16, 1);
    cyc(1, 0, 1, 0, 0, PC, FETCH, 0, 1, 16, 2);
    cyc(1, 0, 0, 0, 0, PC, FETCH, 1, 1, 16, 3);
    cyc(0, 0, 0, 0, 0, PC, EXEC1, 1, 1, 16, 3);
    cyc(0, 0, 0, 0, 0, PC, EXEC2, 1, 1, 16, 3);

    // MFLO in EXEC2 with the divider busy for 5 cycles; busy in EXEC1 is ignored.
    cyc(0, 0, 0, 0, 0, PC, FETCH, 1, 1, 17, 3);
    cyc(0, 0, 0, 1, 1, PC, EXEC1, 1, 1, 17, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 1, PC, EXEC2, 0, 1, 17, 3 + i);
    end
    cyc(0, 0, 0, 0, 1, PC, EXEC2, 1, 1, 17, 8);

    // Busy divider without an MFHI/MFLO does not hold.
    cyc(0, 0, 0, 1, 0, PC, FETCH, 1, 1, 18, 8);
    cyc(0, 0, 0, 1, 0, PC, EXEC1, 1, 1, 18, 8);
    cyc(0, 0, 0, 1, 0, PC, EXEC2, 1, 1, 18, 8);

    // Waitrequest without a request, a write stall, then mem+md stall together.
    cyc(0, 0, 1, 0, 0, PC, FETCH, 1, 1, 19, 8);
    cyc(0, 1, 1, 0, 0, PC, EXEC1, 0, 1, 19, 8);
    cyc(0, 1, 0, 0, 0, PC, EXEC1, 1, 1, 19, 9);
    cyc(1, 0, 1, 1, 1, PC, EXEC2, 0, 1, 19, 9);
    cyc(0, 0, 0, 0, 1, PC, EXEC2, 1, 1, 19, 10);

    // Reset from FETCH with no hold: advance still reflects the inputs.
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, PC, FETCH, 1, 1, 20, 10);
    reset = 1'b0;

    // Two instructions, then fetch from address 0 halts.
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0, PC, st_of(i % 3), 1, 1, i / 3, 0);
    end
    cyc(1, 0, 0, 0, 0, 32'd0, FETCH, 1, 1, 2, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, i[1], i[0], 1, 1, PC + 32'(i), HALTED, 0, 0, 2, 0);
    end

    // Reset pulse from HALTED.
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, PC, HALTED, 0, 0, 2, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, PC, st_of(i), 1, 1, 0, 0);
    end

    // Reset during a held EXEC1 abandons the access and clears counters.
    cyc(0, 0, 0, 0, 0, PC, FETCH, 1, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, PC, EXEC1, 0, 1, 1, 0);
    reset = 1'b1;
    cyc(1, 0, 1, 0, 0, PC, EXEC1, 0, 1, 1, 1);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, PC, FETCH, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, PC, EXEC1, 1, 1, 0, 0);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
